// File: rtl/twiddle_gen_if.sv
// Request/response bundle for twiddle_gen: addr/inv request channel and
// tw_re/tw_im result channel, each with a valid/ready handshake.
interface twiddle_gen_if #(
    parameter int LOG2N = 7,
    parameter int TW_W  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [LOG2N-1:0] addr;
    logic             inv;
    logic             tw_valid;
    logic             tw_ready;
    logic [TW_W-1:0]  tw_re;
    logic [TW_W-1:0]  tw_im;

    modport master (
        output in_valid, addr, inv, tw_ready,
        input  in_ready, tw_valid, tw_re, tw_im
    );

    modport slave (
        input  in_valid, addr, inv, tw_ready,
        output in_ready, tw_valid, tw_re, tw_im
    );
endinterface

// File: rtl/twiddle_gen.sv
// FFT twiddle generator: quarter-wave cosine table folded to full circle, 2-stage elastic pipeline.
// Optional macro TWIDDLE_ZERO_BYPASS_EN: addr=0 emits 0/0 as a multiplier-bypass marker.
module twiddle_gen #(
    parameter int LOG2N = 7,
    parameter int TW_W  = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    twiddle_gen_if.slave  bus
);
    localparam int N  = 1 << LOG2N;
    localparam int QN = N / 4;
    localparam int RW = LOG2N - 2;
    localparam logic [TW_W-1:0] POS_MAX = {1'b0, {(TW_W-1){1'b1}}};

    function automatic logic [TW_W-1:0] cos_mag(input int k);
        real ang, v;
        ang = 2.0 * 3.141592653589793 * real'(k) / real'(N);
        v   = $cos(ang) * (2.0 ** (TW_W - 1));
        return TW_W'($rtoi(v + 0.5));
    endfunction

    // Signed result from sign + magnitude; +2^(TW_W-1) has no encoding and clamps.
    function automatic logic [TW_W-1:0] apply_sign(input logic neg, input logic [TW_W-1:0] mag);
        if (neg)               return TW_W'(~mag + 1'b1);
        else if (mag[TW_W-1])  return POS_MAX;
        else                   return mag;
    endfunction

    typedef struct packed {
        logic [TW_W-1:0] mag_a;   // C(r)
        logic [TW_W-1:0] mag_b;   // C(N/4 - r)
        logic [1:0]      q;
        logic            inv;
    } s1_t;

    // Quarter-wave table, entries 0..N/4, fixed at elaboration.
    logic [QN:0][TW_W-1:0] cos_tab;
    for (genvar k = 0; k <= QN; k++) begin : g_tab
        localparam logic [TW_W-1:0] MAG = cos_mag(k);
        assign cos_tab[k] = MAG;
    end

    logic s1_valid, s2_valid;
    logic s1_load, s2_load, accept;
    s1_t  s1;
    logic [TW_W-1:0] tw_re_q, tw_im_q;

    logic [1:0]    q_in;
    logic [RW-1:0] r_in;
    logic [RW:0]   r_idx, r_cmp;

    assign q_in  = bus.addr[LOG2N-1 -: 2];
    assign r_in  = bus.addr[RW-1:0];
    assign r_idx = {1'b0, r_in};
    assign r_cmp = (RW+1)'(QN) - r_idx;

    assign s2_load      = !s2_valid || bus.tw_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign accept       = bus.in_valid && s1_load;
    assign bus.in_ready = s1_load;
    assign bus.tw_valid = s2_valid;
    assign bus.tw_re    = tw_re_q;
    assign bus.tw_im    = tw_im_q;

`ifdef TWIDDLE_ZERO_BYPASS_EN
    logic s1_zero;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
`ifdef TWIDDLE_ZERO_BYPASS_EN
            s1_zero  <= 1'b0;
`endif
        end else begin
            if (s1_load)
                s1_valid <= bus.in_valid;
            if (accept) begin
                s1.mag_a <= cos_tab[r_idx];
                s1.mag_b <= cos_tab[r_cmp];
                s1.q     <= q_in;
                s1.inv   <= bus.inv;
`ifdef TWIDDLE_ZERO_BYPASS_EN
                s1_zero  <= (bus.addr == '0);
`endif
            end
        end
    end

    // Quadrant fold: pick which magnitude feeds each component and its sign.
    logic            neg_re, neg_im;
    logic [TW_W-1:0] mag_re, mag_im;
    logic [TW_W-1:0] nxt_re, nxt_im;

    always_comb begin
        neg_re = 1'b0;
        neg_im = 1'b0;
        mag_re = s1.mag_a;
        mag_im = s1.mag_b;
        case (s1.q)
            2'd0: begin mag_re = s1.mag_a; neg_re = 1'b0; mag_im = s1.mag_b; neg_im = 1'b1; end
            2'd1: begin mag_re = s1.mag_b; neg_re = 1'b1; mag_im = s1.mag_a; neg_im = 1'b1; end
            2'd2: begin mag_re = s1.mag_a; neg_re = 1'b1; mag_im = s1.mag_b; neg_im = 1'b0; end
            default: begin mag_re = s1.mag_b; neg_re = 1'b0; mag_im = s1.mag_a; neg_im = 1'b0; end
        endcase
        nxt_re = apply_sign(neg_re, mag_re);
        nxt_im = apply_sign(neg_im ^ s1.inv, mag_im);
`ifdef TWIDDLE_ZERO_BYPASS_EN
        if (s1_zero) begin
            nxt_re = '0;
            nxt_im = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            tw_re_q  <= '0;
            tw_im_q  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                tw_re_q <= nxt_re;
                tw_im_q <= nxt_im;
            end
        end
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: trig-based reference queue checked every cycle,
// plus directed literal lookups, a stalled stream and a mid-stream reset.
module tb_twiddle_gen;
    localparam int LOG2N = 7;
    localparam int TW_W  = 16;
    localparam int N     = 1 << LOG2N;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    twiddle_gen_if #(.LOG2N(LOG2N), .TW_W(TW_W)) bus();
    twiddle_gen #(.LOG2N(LOG2N), .TW_W(TW_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall_cnt = 0;
    int emitted   = 0;
    bit rdy_rand  = 1'b0;
    bit rdy_val   = 1'b1;

    typedef struct {
        int addr;
        bit inv;
        int acc_cyc;
        int acc_stall;
    } req_t;
    req_t exp_q[$];

    bit          prev_stall = 1'b0;
    logic [15:0] prev_re, prev_im;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: w = cos(2*pi*n/N) -/+ j*sin(2*pi*n/N), scaled by 2^15.
    task automatic model(input int a, input bit iv, output int re, output int im);
        real ang;
        ang = 2.0 * 3.141592653589793 * real'(a) / real'(N);
        re  = sat16(rnd($cos(ang) * 32768.0));
        im  = sat16(rnd((iv ? 1.0 : -1.0) * $sin(ang) * 32768.0));
`ifdef TWIDDLE_ZERO_BYPASS_EN
        if (a == 0) begin re = 0; im = 0; end
`endif
    endtask

    initial begin
        bus.tw_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            bus.tw_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    always @(negedge clock) begin
        int er, ei, ar, ai;
        bit exp_rdy;
        req_t r;
        if (!reset_n) begin
            chk("rst_tw_valid", bus.tw_valid == 1'b0, int'(bus.tw_valid), 0);
            chk("rst_tw_data", bus.tw_re == 16'h0 && bus.tw_im == 16'h0, int'({bus.tw_re, bus.tw_im}), 0);
            chk("rst_in_ready", bus.in_ready == 1'b1, int'(bus.in_ready), 1);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_rdy = !(exp_q.size() == 2 && !bus.tw_ready);
            chk("in_ready", bus.in_ready == exp_rdy, int'(bus.in_ready), int'(exp_rdy));
            if (prev_stall)
                chk("hold_stable", bus.tw_valid && bus.tw_re == prev_re && bus.tw_im == prev_im,
                    int'({bus.tw_re, bus.tw_im}), int'({prev_re, prev_im}));
            if (bus.tw_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1'b0, int'(bus.tw_valid), 0);
                end else if (bus.tw_ready) begin
                    r = exp_q.pop_front();
                    model(r.addr, r.inv, er, ei);
                    ar = int'($signed(bus.tw_re));
                    ai = int'($signed(bus.tw_im));
                    chk("model_re", (ar - er) <= 1 && (er - ar) <= 1, ar, er);
                    chk("model_im", (ai - ei) <= 1 && (ei - ai) <= 1, ai, ei);
                    if (r.acc_stall == stall_cnt)
                        chk("latency", cyc - r.acc_cyc == 2, cyc - r.acc_cyc, 2);
                    emitted++;
                end
            end
            prev_stall = bus.tw_valid && !bus.tw_ready;
            if (prev_stall) stall_cnt++;
            prev_re = bus.tw_re;
            prev_im = bus.tw_im;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back('{bus.addr, bus.inv, cyc, stall_cnt});
        end
    end

    task automatic lookup(input logic [6:0] a, input logic iv, input logic [15:0] er,
                          input logic [15:0] ei, input string nm);
        bus.addr     = a;
        bus.inv      = iv;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        chk({nm, "_valid"}, bus.tw_valid == 1'b1, int'(bus.tw_valid), 1);
        chk({nm, "_re"}, bus.tw_re == er, int'(bus.tw_re), int'(er));
        chk({nm, "_im"}, bus.tw_im == ei, int'(bus.tw_im), int'(ei));
        @(posedge clock); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int mr, mi, base, tmo;
        bit hs;
        bus.in_valid = 1'b0;
        bus.addr     = '0;
        bus.inv      = 1'b0;

        model(16, 1'b0, mr, mi);
        chk("pin_model16_re", mr == 23170, mr, 23170);
        chk("pin_model16_im", mi == -23170, mi, -23170);
        model(1, 1'b1, mr, mi);
        chk("pin_model1_im", mi == 1608, mi, 1608);

        cycles(3);
        reset_n = 1'b1;
        chk("ready_after_release", bus.in_ready == 1'b1, int'(bus.in_ready), 1);
        cycles(2);

        lookup(7'd1,  1'b0, 16'h7FD9, 16'hF9B8, "a1");
        lookup(7'd16, 1'b0, 16'h5A82, 16'hA57E, "a16");
        lookup(7'd32, 1'b0, 16'h0000, 16'h8000, "a32");
        lookup(7'd64, 1'b0, 16'h8000, 16'h0000, "a64");
        lookup(7'd96, 1'b0, 16'h0000, 16'h7FFF, "a96");
        lookup(7'd1,  1'b1, 16'h7FD9, 16'h0648, "a1_inv");
        lookup(7'd32, 1'b1, 16'h0000, 16'h7FFF, "a32_inv");
`ifdef TWIDDLE_ZERO_BYPASS_EN
        lookup(7'd0,  1'b0, 16'h0000, 16'h0000, "a0");
        lookup(7'd0,  1'b1, 16'h0000, 16'h0000, "a0_inv");
`else
        lookup(7'd0,  1'b0, 16'h7FFF, 16'h0000, "a0");
`endif

        // Full-circle stream with random back-pressure.
        base     = emitted;
        rdy_rand = 1'b1;
        for (int n = 0; n < N; n++) begin
            bus.addr     = 7'(n);
            bus.inv      = (n % 3 == 0);
            bus.in_valid = 1'b1;
            tmo = 0;
            do begin
                @(negedge clock);
                hs = bus.in_ready;
                @(posedge clock); #1;
                tmo++;
            end while (!hs && tmo < 200);
            if (!hs) chk("stream_accept_timeout", 1'b0, tmo, 200);
        end
        bus.in_valid = 1'b0;
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 50) begin
            @(posedge clock); #1;
            tmo++;
        end
        chk("stream_drain", exp_q.size() == 0, exp_q.size(), 0);
        chk("stream_count", emitted - base == N, emitted - base, N);

        // Two requests parked behind a stalled consumer, then reset.
        rdy_val = 1'b0;
        cycles(2);
        bus.addr = 7'd5; bus.inv = 1'b0; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.addr = 7'd6;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("inflight_valid", bus.tw_valid == 1'b1, int'(bus.tw_valid), 1);
        chk("inflight_full", bus.in_ready == 1'b0, int'(bus.in_ready), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.tw_valid == 1'b0, int'(bus.tw_valid), 0);
        chk("async_rst_data", bus.tw_re == 16'h0 && bus.tw_im == 16'h0, int'({bus.tw_re, bus.tw_im}), 0);
        rdy_val = 1'b1;
        cycles(3);
        reset_n = 1'b1;
        cycles(4);
        chk("no_stale_after_rst", bus.tw_valid == 1'b0, int'(bus.tw_valid), 0);
        lookup(7'd16, 1'b0, 16'h5A82, 16'hA57E, "post_rst_a16");
        lookup(7'd127, 1'b0, 16'h7FD9, 16'h0648, "a127");

        cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 The block SHALL have parameter LOG2N, default 7, meaning log2 of FFT size N; legal range 3..12.
REQ-002 The block SHALL have parameter TW_W, default 16, meaning twiddle word width (signed two's complement); legal range 8..24.
REQ-003 The block SHALL have port clock  input  1  master clock, all flops rising-edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  request present.
REQ-006 The block SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 The block SHALL have port addr  input  LOG2N  twiddle number n, 0..N-1.
REQ-008 The block SHALL have port inv  input  1  1 = inverse FFT (conjugate twiddle), sampled with addr.
REQ-009 The block SHALL have port tw_valid  output  1  tw_re/tw_im valid.
REQ-010 The block SHALL have port tw_ready  input  1  consumer accepts when tw_valid && tw_ready.
REQ-011 The block SHALL have ports tw_re and tw_im  output  TW_W each  twiddle real and imaginary parts.

Function
REQ-012 Output SHALL equal wn = cos(2*pi*n/N) - j*sin(2*pi*n/N), with inv=1 giving the conjugate (+j*sin).
REQ-013 Storage SHALL be a quarter-wave magnitude table C(k) = round(cos(2*pi*k/N) * 2^(TW_W-1)), k = 0..N/4 (N/4+1 entries, TW_W-bit unsigned), built at elaboration; no full-wave table.
REQ-014 Fold: q = addr[LOG2N-1:LOG2N-2], r = remaining low bits; q0: (C(r), -C(N/4-r)); q1: (-C(N/4-r), -C(r)); q2: (-C(r), +C(N/4-r)); q3: (+C(N/4-r), +C(r)).
REQ-015 Sign/width: magnitude 2^(TW_W-1) with negative sign SHALL output -2^(TW_W-1); with positive sign it SHALL saturate to 2^(TW_W-1)-1; inv negation of -2^(TW_W-1) SHALL saturate to 2^(TW_W-1)-1.
REQ-016 The pipeline SHALL have two registered stages: S1 = table lookup plus captured q and inv; S2 = sign/fold/saturate; latency from acceptance to tw_valid SHALL be 2 cycles with no stall.
REQ-017 Throughput SHALL be one result per cycle while tw_ready=1.
REQ-018 S2 SHALL load when !s2_valid || tw_ready; S1 SHALL load when !s1_valid || S2 loads; in_ready = !s1_valid || !s2_valid || tw_ready.
REQ-019 While tw_valid=1 and tw_ready=0, tw_re/tw_im SHALL hold stable and no result SHALL be lost or duplicated.
REQ-020 A simultaneous accept and emit SHALL both complete in the same cycle.
REQ-021 Out-of-order delivery SHALL NOT occur; results SHALL leave in acceptance order.
REQ-022 addr wrap N-1 -> 0 SHALL need no special handling.

Reset
REQ-023 reset_n low SHALL asynchronously clear s1_valid, s2_valid and tw_valid to 0, and tw_re/tw_im to 0.
REQ-024 In-flight requests at reset SHALL be discarded.
REQ-025 in_ready SHALL be 1 during reset and the first cycle after release.
REQ-026 Data registers SHALL be reset to 0.

Configuration
REQ-027 Macro TWIDDLE_ZERO_BYPASS_EN defined: addr=0 SHALL output tw_re=0, tw_im=0 (multiplier-bypass marker, any inv).
REQ-028 Macro TWIDDLE_ZERO_BYPASS_EN undefined: addr=0 SHALL output tw_re=2^(TW_W-1)-1, tw_im=0.
REQ-029 Latency and handshake SHALL be identical with or without TWIDDLE_ZERO_BYPASS_EN.

Verification (LOG2N=7, TW_W=16)
REQ-030 Directed lookups, inv=0, tw_ready=1: addr 1 -> 7FD9/F9B8; 16 -> 5A82/A57E; 32 -> 0000/8000; 64 -> 8000/0000; 96 -> 0000/7FFF; each result 2 cycles after accept.
REQ-031 inv=1, addr 1 -> 7FD9/0648; addr 32 -> 0000/7FFF.
REQ-032 addr 0 -> 0000/0000 with TWIDDLE_ZERO_BYPASS_EN, 7FFF/0000 without.
REQ-033 Stream addr 0..127 with tw_ready toggling pseudo-randomly -> 128 results in order, each matching a golden model computed from cos/sin, error <= 1 LSB, held stable while stalled; in_ready=0 only when both stages full and tw_ready=0.
REQ-034 reset_n pulsed low mid-stream with 2 requests in flight -> tw_valid=0 immediately; no stale output after release; next request returns correct value at latency 2.
